job_arbiter: RTL and testbench

JOB_ARBITER -- requirements
Module: job_arbiter

---
 rtl/job_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_job_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/job_arbiter.sv
// -----------------------------------------------------------------------------
// job_arbiter
//
// Round-robin arbiter that lets NREQ requesters share one job engine. Each job
// runs through the sequence IDLE -> START -> WAIT -> DONE -> IDLE:
//   IDLE  : pick the first requesting index at or after the rr pointer
//   START : one-cycle eng_start pulse to the engine, grant and eng_id valid
//   WAIT  : hold grant until eng_done (or, optionally, a timeout)
//   DONE  : one-cycle ack to the owner, with err; rr pointer advances past it
//
// Optional feature macro: JOB_ARBITER_TIMEOUT_EN
//   Defined   : WAIT is bounded to TIMEOUT cycles; a timed-out job ends with
//               err = 1. If eng_done and the timeout coincide, eng_done wins.
//   Undefined : WAIT ends only on eng_done, err is constant 0, TIMEOUT unused.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   TIMEOUT   maximum WAIT cycles before forced completion (>= 2)
//
// Ports
//   clock      in   single clock, all state on the rising edge
//   reset      in   synchronous, active-high reset
//   req        in   [NREQ]   per-requester job request (level, held until ack)
//   grant      out  [NREQ]   one-hot owner of the engine, zero when idle
//   ack        out  [NREQ]   one-cycle completion pulse to the owner
//   err        out           valid with ack; 1 = job ended by timeout
//   eng_start  out           one-cycle start pulse to the engine
//   eng_id     out  [clog2]  index of the current owner (0 when idle)
//   eng_done   in            engine completion pulse, only honoured in WAIT
//
// Outputs are decoded from registered state only, so no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module job_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           ack,
  output logic                      err,
  output logic                      eng_start,
  output logic [$clog2(NREQ)-1:0]   eng_id,
  input  logic                      eng_done
);

  localparam int IDW = $clog2(NREQ);

  // Reject illegal configurations at elaboration time.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_check
    $error("job_arbiter: NREQ must be 2..8 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   rr_ptr;
  logic [NREQ-1:0]  owner_oh;
  logic             sel_valid;
  logic [IDW-1:0]   sel_idx;
  logic             timeout_hit;
  logic             job_err;

  // Index that sits 'off' places after 'base', wrapping modulo NREQ. Works for
  // NREQ values that are not a power of two.
  function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base,
                                             input int             off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // Round-robin search: scanning from the farthest offset down to the pointer
  // lets the nearest requester (first at or after rr_ptr) win.
  // NOTE: every combinational output gets a default before any branch so that
  // no path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[rot_idx(rr_ptr, i)]) begin
        sel_valid = 1'b1;
        sel_idx   = rot_idx(rr_ptr, i);
      end
    end
  end

  assign owner_oh = NREQ'(1) << owner;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // NOTE: reset is sampled on the clock edge (synchronous), and sequential
  // state uses non-blocking assignment so every register updates from the
  // pre-edge values regardless of block ordering.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. eng_done is only looked at in WAIT, so stray pulses
  // elsewhere have no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (sel_valid) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  if (eng_done || timeout_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (state + owner registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    ack       = '0;
    err       = 1'b0;
    eng_start = 1'b0;
    eng_id    = '0;
    case (state)
      IDLE: ;
      START: begin
        grant     = owner_oh;
        eng_start = 1'b1;
        eng_id    = owner;
      end
      WAIT: begin
        grant  = owner_oh;
        eng_id = owner;
      end
      DONE: begin
        grant  = owner_oh;
        ack    = owner_oh;
        err    = job_err;
        eng_id = owner;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Owner and round-robin pointer. Owner is latched once per job in IDLE, so a
  // requester dropping req mid-job does not disturb the running job.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && sel_valid) owner <= sel_idx;
      if (state == DONE) begin
        rr_ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

`ifdef JOB_ARBITER_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // WAIT timeout. The counter is cleared in START so it reads 0 on the first
  // WAIT cycle; reaching TIMEOUT-1 ends the job after TIMEOUT WAIT cycles.
  // ---------------------------------------------------------------------------
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !eng_done && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // Refreshed every WAIT cycle; the value from the final WAIT cycle is the
      // one presented in DONE. eng_done takes precedence over the timeout.
      if (state == WAIT) err_q <= timeout_hit && !eng_done;
    end
  end

  assign job_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign job_err     = 1'b0;
`endif

endmodule

// File: tb/tb_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_job_arbiter
//
// Directed testbench for job_arbiter (NREQ = 4, TIMEOUT = 8). Each scenario
// task drives inputs just after a rising edge and compares the registered
// outputs {grant, ack, err, eng_start, eng_id} for that cycle against
// hand-derived values. The timeout scenario follows JOB_ARBITER_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_job_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       eng_done;
  logic [3:0] grant;
  logic [3:0] ack;
  logic       err;
  logic       eng_start;
  logic [1:0] eng_id;

  int errors = 0;
  int checks = 0;

  // Observed and expected {grant, ack, err, eng_start, eng_id}.
  logic [11:0] obs;
  logic [11:0] exp_v;

  job_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .ack       (ack),
    .err       (err),
    .eng_start (eng_start),
    .eng_id    (eng_id),
    .eng_done  (eng_done)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] ov(input logic [3:0] g, input logic [3:0] a,
                                     input logic e, input logic s,
                                     input logic [1:0] id);
    return {g, a, e, s, id};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Advance one cycle and sample the outputs of the new cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    obs = {grant, ack, err, eng_start, eng_id};
  endtask

  // Two reset cycles; returns in an IDLE cycle with reset already released.
  task automatic apply_reset();
    reset    = 1'b1;
    req      = 4'b0000;
    eng_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reset state and reset priority over active inputs.
  task automatic test_reset();
    reset    = 1'b1;
    req      = 4'b1111;
    eng_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_hold c%0d: got %b want %b", c, obs, exp_v);
      end
    end
    reset    = 1'b0;
    eng_done = 1'b0;
    tick();
    exp_v = ov(4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want %b", obs, exp_v);
    end
  endtask

  // Single job: req at t, eng_done at t+5 -> grant t+1..t+6, ack t+6.
  task automatic test_single();
    apply_reset();
    req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      tick();
      eng_done = (c == 5);
      if (c == 6) req = 4'b0000;
      case (c)
        1:       exp_v = ov(4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0);
        6:       exp_v = ov(4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0);
        7:       exp_v = '0;
        default: exp_v = ov(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
      endcase
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single c%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  // All requesters held; eng_done 3 cycles after each start.
  task automatic test_round_robin();
    logic [1:0] id;
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % 4);
      for (int p = 0; p < 6; p++) begin
        tick();
        eng_done = (p == 3);
        if (k == 4 && p == 5) req = 4'b0000;
        case (p)
          0:       exp_v = ov(oh(id), 4'b0000, 1'b0, 1'b1, id);
          4:       exp_v = ov(oh(id), oh(id), 1'b0, 1'b0, id);
          5:       exp_v = '0;
          default: exp_v = ov(oh(id), 4'b0000, 1'b0, 1'b0, id);
        endcase
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL round_robin job%0d p%0d: got %b want %b", k, p, obs, exp_v);
        end
      end
    end
    tick();
    exp_v = '0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL round_robin idle: got %b want %b", obs, exp_v);
    end
  endtask

  // Pointer skip and wrap: job on 2 -> ptr 3; 0011 -> 0 then 1; 1000 -> 3,
  // pointer wraps to 0 so 1001 selects 0.
  task automatic test_skip_wrap();
    logic [3:0] req_t [5];
    logic [1:0] own_t [5];
    req_t = '{4'b0100, 4'b0011, 4'b0011, 4'b1000, 4'b1001};
    own_t = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
    apply_reset();
    for (int j = 0; j < 5; j++) begin
      req = req_t[j];
      for (int p = 0; p < 4; p++) begin
        tick();
        eng_done = (p == 1);
        if (p == 2) req = 4'b0000;
        case (p)
          0:       exp_v = ov(oh(own_t[j]), 4'b0000, 1'b0, 1'b1, own_t[j]);
          1:       exp_v = ov(oh(own_t[j]), 4'b0000, 1'b0, 1'b0, own_t[j]);
          2:       exp_v = ov(oh(own_t[j]), oh(own_t[j]), 1'b0, 1'b0, own_t[j]);
          default: exp_v = '0;
        endcase
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL skip_wrap job%0d p%0d: got %b want %b", j, p, obs, exp_v);
        end
      end
    end
  endtask

`ifdef JOB_ARBITER_TIMEOUT_EN
  // No eng_done: ack with err exactly 9 cycles after eng_start. Then eng_done
  // on the 8th WAIT cycle coincides with the timeout and wins (err = 0).
  task automatic test_timeout();
    apply_reset();
    for (int job = 0; job < 2; job++) begin
      req = 4'b0100;
      for (int c = 0; c <= 10; c++) begin
        tick();
        eng_done = (job == 1 && c == 8);
        if (c == 9) req = 4'b0000;
        if (c == 0)       exp_v = ov(4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2);
        else if (c <= 8)  exp_v = ov(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2);
        else if (c == 9)  exp_v = ov(4'b0100, 4'b0100, (job == 0), 1'b0, 2'd2);
        else              exp_v = '0;
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL timeout job%0d c%0d: got %b want %b", job, c, obs, exp_v);
        end
      end
    end
  endtask
`else
  // Without the timeout feature WAIT lasts until eng_done and err stays 0.
  task automatic test_timeout();
    apply_reset();
    req = 4'b0100;
    for (int c = 0; c <= 24; c++) begin
      tick();
      eng_done = (c == 22);
      if (c == 23) req = 4'b0000;
      if (c == 0)       exp_v = ov(4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2);
      else if (c <= 22) exp_v = ov(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2);
      else if (c == 23) exp_v = ov(4'b0100, 4'b0100, 1'b0, 1'b0, 2'd2);
      else              exp_v = '0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL no_timeout c%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask
`endif

  // Reset in WAIT (together with eng_done): outputs clear next cycle, no ack,
  // held req is re-granted two cycles after the reset cycle.
  task automatic test_reset_mid_wait();
    apply_reset();
    req = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      tick();
      reset    = (c == 3);
      eng_done = (c == 3 || c == 6);
      if (c == 7) req = 4'b0000;
      case (c)
        1, 5:    exp_v = ov(4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1);
        2, 3, 6: exp_v = ov(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd1);
        7:       exp_v = ov(4'b0010, 4'b0010, 1'b0, 1'b0, 2'd1);
        default: exp_v = '0;
      endcase
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_wait c%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  // Stray eng_done in IDLE, START and DONE; req dropped during WAIT.
  task automatic test_stray_done();
    apply_reset();
    eng_done = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      case (c)
        1: begin req = 4'b0001; eng_done = 1'b1; end
        2: eng_done = 1'b1;
        3: begin req = 4'b0000; eng_done = 1'b0; end
        4: eng_done = 1'b1;
        5: eng_done = 1'b1;
        default: eng_done = 1'b0;
      endcase
      case (c)
        2:       exp_v = ov(4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0);
        3, 4:    exp_v = ov(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
        5:       exp_v = ov(4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0);
        default: exp_v = '0;
      endcase
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stray_done c%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    eng_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_timeout();
    test_reset_mid_wait();
    test_stray_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
